multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 The block SHALL have parameter N, default 4: chunk width in bits, processed per cycle; N >= 1.
REQ-002 The block SHALL have parameter K, default 4: number of chunks per operand (operand width W = N*K); K >= 1.
REQ-003 The block SHALL run on one clock and a synchronous, active-high reset, with ports as follows:
  - clk  input  1  rising-edge clock, only clock.
  - rst  input  1  synchronous, active-high reset.
  - in_valid  input  1  operand pair offered.
  - in_ready  output  1  block can accept operands.
  - a  input  W  operand A, unsigned.
  - b  input  W  operand B, unsigned.
  - out_valid  output  1  result available.
  - out_ready  input  1  consumer takes result.
  - sum  output  W+1  A+B, bit W = final carry.
  - busy  output  1  addition in progress (RUN state).

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN; out_valid SHALL be 1 only in DONE.
REQ-006 An accept SHALL occur on a rising edge with in_valid=1 and state IDLE; at that edge: latch a and b, chunk index <= 0, carry <= 0, state <= RUN.
REQ-007 in_valid in RUN or DONE SHALL be ignored; a and b changes after accept SHALL NOT affect the result.
REQ-008 Each RUN edge SHALL process chunk i = bits [i*N +: N]: s1 = A_i + B_i (N+1 bits); s2 = s1[N-1:0] + carry (N+1 bits); sum[i*N +: N] <= s2[N-1:0]; carry <= s1[N] | s2[N]; i <= i+1.
REQ-009 On the RUN edge processing chunk K-1: sum[W] <= carry-out of that chunk; state <= DONE.
REQ-010 Latency: out_valid SHALL rise exactly K edges after the accepting edge.
REQ-011 In DONE, sum SHALL hold stable while out_ready=0; the edge with out_ready=1 SHALL return to IDLE (in_ready=1 next cycle); sum SHALL retain its value in IDLE until the next RUN begins.
REQ-012 Arithmetic SHALL be exact unsigned W-bit addition; maximum result 2^(W+1)-2 (all-ones + all-ones) SHALL be produced without loss.
REQ-013 K=1 SHALL degenerate to a single RUN cycle, using the same rules.
REQ-014 A new operand pair SHALL NOT be accepted in the same cycle as the result handshake (no overlap; throughput one addition per K+2 cycles minimum).

Reset
REQ-015 While rst=1 at a rising edge: state <= IDLE, sum <= 0, carry <= 0, chunk index <= 0.
REQ-016 After reset: in_ready=1, out_valid=0, busy=0, sum=0.
REQ-017 Reset in RUN or DONE SHALL abort the operation, discard operands and partial result, and produce no out_valid pulse.

Structure
REQ-018 Shared package add_seq_pkg SHALL hold default N and K, and the state type (IDLE, RUN, DONE) with its encoding.
REQ-019 The per-chunk datapath SHALL reuse the team's combinational nbit_adder (N-bit, carry-in tied 0, N+1-bit sum): one instance for s1, a second for s2 (B operand = zero-extended carry).
REQ-020 Chunk selection, carry register, sum register and FSM SHALL live in multiword_add_seq; no further sub-modules.

Verification (N=4, K=4, W=16)
REQ-021 The bench SHALL cover the following directed scenarios:
  - Carry propagation: a=0x00FF, b=0x0001 -> sum=0x00100, out_valid 4 edges after accept.
  - Max operands: a=0xFFFF, b=0xFFFF -> sum=0x1FFFE.
  - Backpressure: out_ready=0 for 3 cycles in DONE -> sum and out_valid stable, in_ready=0, then one handshake -> IDLE.
  - Busy ignore: a second in_valid with a=0x1234 during RUN -> ignored, first result unaffected.
  - Mid-run reset: rst at chunk index 2 -> IDLE next cycle, sum=0, no out_valid; next add 0x0001+0x0001 -> 0x00002.
  - K=1, N=4: a=0xF, b=0x1 -> sum=0x10, out_valid 1 edge after accept.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared definitions for the chunked sequential adder.
// Holds default geometry and the controller state encoding.
// Combinational content only; no timing behaviour.
package add_seq_pkg;

  localparam int unsigned N_DEFAULT = 4;  // chunk width in bits
  localparam int unsigned K_DEFAULT = 4;  // chunks per operand

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/nbit_adder.sv
// Purpose: N-bit unsigned adder with carry-in, N+1-bit result.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module nbit_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// Purpose: adds two W=N*K-bit operands one N-bit chunk per cycle, ripple via carry reg.
// Latency: out_valid rises exactly K edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module multiword_add_seq
  import add_seq_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int K = K_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K:0]   sum,
  output logic           busy
);

  localparam int W     = N * K;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W:0]       sum_q, sum_d;

  logic [N-1:0]     a_chunk, b_chunk, carry_ext;
  logic [N:0]       s1, s2;
  logic             chunk_cout;

  assign a_chunk = a_q[idx_q*N +: N];
  assign b_chunk = b_q[idx_q*N +: N];

  // Zero-extend the carry register to the chunk width, safe for N=1.
  always_comb begin
    carry_ext    = '0;
    carry_ext[0] = carry_q;
  end

  nbit_adder #(.N(N)) u_add_ab (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (1'b0),
    .sum (s1)
  );

  nbit_adder #(.N(N)) u_add_carry (
    .a   (s1[N-1:0]),
    .b   (carry_ext),
    .cin (1'b0),
    .sum (s2)
  );

  // At most one of the two partial sums can carry, so OR gives the chunk carry-out.
  assign chunk_cout = s1[N] | s2[N];

  // Next-state and output decode for the IDLE/RUN/DONE controller and datapath.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy                 = 1'b1;
        sum_d[idx_q*N +: N]  = s2[N-1:0];
        carry_d              = chunk_cout;
        idx_d                = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d[W] = chunk_cout;
          idx_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Return to IDLE only; a new accept needs the following edge.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: N=4,K=4 main instance plus a K=1 instance.
// Expected sums are queued at accept and compared when the result handshake is seen.
// Inputs change 1 time unit after rising edges; outputs are sampled there or at falling edges.
module tb_multiword_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [16:0] sum;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [3:0]  a1, b1;
  logic [4:0]  sum1;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] sb[$];
  logic [4:0]  sb1[$];

  multiword_add_seq #(.N(4), .K(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy)
  );

  multiword_add_seq #(.N(4), .K(1)) dut_k1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: one pop per result handshake on each instance.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 32'(sum), 32'h0);
      else chk("sb_sum", 32'(sum), 32'(sb.pop_front()));
    end
    if (out_valid1 && out_ready1) begin
      if (sb1.size() == 0) chk("unexpected_result_k1", 32'(sum1), 32'h0);
      else chk("sb_sum_k1", 32'(sum1), 32'(sb1.pop_front()));
    end
  end

  // One addition on the K=4 instance; bp = cycles of out_ready low in DONE,
  // poke = keep in_valid high with a different operand pair through RUN/DONE.
  task automatic run_add(input logic [15:0] xa, input logic [15:0] xb,
                         input int bp, input bit poke);
    int cnt;
    logic [16:0] exp_v;
    exp_v = {1'b0, xa} + {1'b0, xb};
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = xa; b = xb;
    sb.push_back(exp_v);
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_in_run", 32'(in_ready), 32'd0);
    if (poke) begin
      a = 16'h1234; b = 16'h1234;
    end else begin
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    end
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", 32'(cnt), 32'd4);
    chk("done_sum", 32'(sum), 32'(exp_v));
    repeat (bp) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'(exp_v));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("sum_retained", 32'(sum), 32'(exp_v));
    in_valid = 1'b0;
  endtask

  task automatic run_add_k1(input logic [3:0] xa, input logic [3:0] xb);
    int cnt;
    chk("k1_in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; a1 = xa; b1 = xb;
    sb1.push_back({1'b0, xa} + {1'b0, xb});
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    chk("k1_busy", 32'(busy1), 32'd1);
    cnt = 0;
    while (!out_valid1 && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("k1_latency", 32'(cnt), 32'd1);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("k1_idle_ready", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_k1_sum", 32'(sum1), 32'd0);

    // Carry ripples across chunk boundaries.
    run_add(16'h00FF, 16'h0001, 0, 1'b0);
    // Largest possible result.
    run_add(16'hFFFF, 16'hFFFF, 0, 1'b0);
    // Held result under backpressure.
    run_add(16'h8001, 16'h7FFF, 3, 1'b0);
    // Extra in_valid during RUN/DONE and across the handshake edge is ignored.
    run_add(16'h0F0F, 16'h0101, 2, 1'b1);

    // Abort in the middle of an addition, after chunks 0 and 1.
    in_valid = 1'b1; a = 16'hABCD; b = 16'h5432;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_add(16'h0001, 16'h0001, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_add(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // Single-chunk instance.
    run_add_k1(4'hF, 4'h1);
    run_add_k1(4'hF, 4'hF);
    run_add_k1(4'h3, 4'h4);

    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
